// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back stage and register file.
package wb_regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = 32;

  // Hard-wired zero register and named ABI registers
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] SP       = 5'd29;
  localparam logic [4:0] RA       = 5'd31;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB write-back controls, ID read ports and debug taps of the register file.
interface wb_regfile_if
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) ();

  logic              regwriteW;
  logic              memtoregW;
  logic [DATA_W-1:0] alu_outW;
  logic [DATA_W-1:0] dm_outW;
  logic [ADDR_W-1:0] write_regW;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [DATA_W-1:0] resultW;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [CNT_W-1:0]  wr_count;

  // Pipeline side: drives write-back controls and read addresses
  modport master (
    output regwriteW, memtoregW, alu_outW, dm_outW, write_regW,
    output ra1, ra2, dbg_addr,
    input  rd1, rd2, resultW, dbg_data, wr_count
  );

  // Register file side
  modport slave (
    input  regwriteW, memtoregW, alu_outW, dm_outW, write_regW,
    input  ra1, ra2, dbg_addr,
    output rd1, rd2, resultW, dbg_data, wr_count
  );

endinterface

// File: rtl/wb_regfile_mux.sv
// Write-back value select; also reused by the forwarding unit.
module wb_mux #(
  parameter int DATA_W = 32
) (
  input  logic              memtoreg_i,
  input  logic [DATA_W-1:0] alu_out_i,
  input  logic [DATA_W-1:0] dm_out_i,
  output logic [DATA_W-1:0] result_o
);

  // Loads write the memory word, everything else writes the ALU result
  always_comb begin
    result_o = memtoreg_i ? dm_out_i : alu_out_i;
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage: result select, 2**ADDR_W register array with
// write-through bypass to the ID read ports, debug tap and retired-write counter.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  wb_regfile_if.slave  bus
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [CNT_W-1:0]  wr_count_q;
  logic [CNT_W-1:0]  wr_count_d;
  logic [DATA_W-1:0] resultVal;
  logic [DATA_W-1:0] rd1Val;
  logic [DATA_W-1:0] rd2Val;
  logic [DATA_W-1:0] dbgVal;
  logic              realWrite;

  wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
    .memtoreg_i (bus.memtoregW),
    .alu_out_i  (bus.alu_outW),
    .dm_out_i   (bus.dm_outW),
    .result_o   (resultVal)
  );

  // A write only retires when enabled and not aimed at the zero register
  always_comb begin
    realWrite = bus.regwriteW && (bus.write_regW != ZERO_ADDR);
  end

  // Register array: reset wipes everything and drops any colliding write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (realWrite) begin
      regs_q[bus.write_regW] <= resultVal;
    end
  end

  // Next retired-write count, wrapping silently at the counter width
  always_comb begin
    wr_count_d = wr_count_q;
    if (realWrite) begin
      wr_count_d = wr_count_q + CNT_W'(1);
    end
  end

  // Retired-write counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= wr_count_d;
    end
  end

  // Read ports: zero register, then same-cycle bypass, then array contents.
  // The bypass is not gated by reset so a write in flight is always visible.
  always_comb begin
    rd1Val = '0;
    if (bus.ra1 != ZERO_ADDR) begin
      if (bus.regwriteW && (bus.write_regW == bus.ra1)) begin
        rd1Val = resultVal;
      end else begin
        rd1Val = regs_q[bus.ra1];
      end
    end
  end

  // Second read port resolves independently of the first
  always_comb begin
    rd2Val = '0;
    if (bus.ra2 != ZERO_ADDR) begin
      if (bus.regwriteW && (bus.write_regW == bus.ra2)) begin
        rd2Val = resultVal;
      end else begin
        rd2Val = regs_q[bus.ra2];
      end
    end
  end

  // Debug tap shows committed state only, never the bypassed value
  always_comb begin
    dbgVal = '0;
    if (bus.dbg_addr != ZERO_ADDR) begin
      dbgVal = regs_q[bus.dbg_addr];
    end
  end

  assign bus.resultW  = resultVal;
  assign bus.rd1      = rd1Val;
  assign bus.rd2      = rd2Val;
  assign bus.dbg_data = dbgVal;
  assign bus.wr_count = wr_count_q;

endmodule
